// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file write controller.
//   state_e    : controller FSM encoding (StRun accepts writes, StClear sweeps all registers)
//   NREG       : number of registers in the file
//   REG_ADDR_W : register address width
package rf_ctrl_pkg;

  localparam int unsigned NREG       = 8;
  localparam int unsigned REG_ADDR_W = 3;

  typedef enum logic {
    StRun   = 1'b0,
    StClear = 1'b1
  } state_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of the requester handshakes, clear control and register-file write port.
//   req0_* / req1_*  : valid/addr/data from requesters, ready back from the arbiter
//   clr_start        : request a clear of every register
//   clr_busy/clr_done: clear in progress / one-cycle completion pulse
//   rf_write_*       : registered drive to the register-file write port
// Modport slave is the arbiter side; master is the requester/observer side.
interface rf_write_arbiter_if #(
  parameter int unsigned DATA_W = 8
);
  import rf_ctrl_pkg::*;

  logic                  req0_valid;
  logic [REG_ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0]     req0_data;
  logic                  req0_ready;

  logic                  req1_valid;
  logic [REG_ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0]     req1_data;
  logic                  req1_ready;

  logic                  clr_start;
  logic                  clr_busy;
  logic                  clr_done;

  logic                  rf_write_enable;
  logic [REG_ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0]     rf_write_data;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  clr_start,
    output req0_ready, req1_ready,
    output clr_busy, clr_done,
    output rf_write_enable, rf_write_addr, rf_write_data
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output clr_start,
    input  req0_ready, req1_ready,
    input  clr_busy, clr_done,
    input  rf_write_enable, rf_write_addr, rf_write_data
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant logic (purely combinational).
//   valid_i : request valids, bit N = requester N
//   ptr_i   : priority pointer, names the requester that wins when both are valid
//   grant_o : one-hot grant (all zero when nothing is valid)
module rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o    = 2'b00;
    grant_o[0] = valid_i[0] & (~valid_i[1] | ~ptr_i);
    grant_o[1] = valid_i[1] & (~valid_i[0] |  ptr_i);
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates two write requesters onto a single register-file write port and can
// sweep zeros into all registers on request.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : requester handshakes, clear control and registered write-port drive
module rf_write_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  rf_write_arbiter_if.slave   bus
);

  state_e                state_q, state_d;
  logic [REG_ADDR_W-1:0] cnt_q, cnt_d;
  logic                  ptr_q, ptr_d;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  done_q, done_d;

  logic [1:0] grant;
  logic       accept_en;
  logic       xfer0, xfer1;

  rr_arbiter2 u_arb (
    .valid_i ({bus.req1_valid, bus.req0_valid}),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  // A pending clear start outranks any request in the same cycle.
  always_comb begin
    accept_en = (state_q == StRun) & ~bus.clr_start & ~reset;
    xfer0     = accept_en & grant[0];
    xfer1     = accept_en & grant[1];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus.clr_start) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (xfer0) begin
          we_d   = 1'b1;
          addr_d = bus.req0_addr;
          data_d = bus.req0_data;
          ptr_d  = 1'b1;
        end else if (xfer1) begin
          we_d   = 1'b1;
          addr_d = bus.req1_addr;
          data_d = bus.req1_data;
          ptr_d  = 1'b0;
        end
      end
      StClear: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        data_d = '0;
        cnt_d  = cnt_q + REG_ADDR_W'(1);
        if (cnt_q == REG_ADDR_W'(NREG - 1)) begin
          state_d = StRun;
          done_d  = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    bus.req0_ready      = xfer0;
    bus.req1_ready      = xfer1;
    bus.clr_busy        = (state_q == StClear);
    bus.clr_done        = done_q;
    bus.rf_write_enable = we_q;
    bus.rf_write_addr   = addr_q;
    bus.rf_write_data   = data_q;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  logic clock;
  logic reset;

  rf_write_arbiter_if #(.DATA_W(8)) bus ();

  rf_write_arbiter #(.DATA_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic       clr;
    logic       v0;
    logic [2:0] a0;
    logic [7:0] d0;
    logic       v1;
    logic [2:0] a1;
    logic [7:0] d1;
    logic       r0;    // expected ready0 in this cycle
    logic       r1;
    logic       busy;
    logic       we;    // expected registered outputs after the edge
    logic [2:0] addr;
    logic [7:0] data;
    logic       done;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a falling edge: drive, check combinational outputs, cross the
  // rising edge, then check the registered outputs.
  task automatic run_cycle(input vec_t v);
    reset          = v.rst;
    bus.clr_start  = v.clr;
    bus.req0_valid = v.v0;
    bus.req0_addr  = v.a0;
    bus.req0_data  = v.d0;
    bus.req1_valid = v.v1;
    bus.req1_addr  = v.a1;
    bus.req1_data  = v.d1;
    #2;
    check({v.name, ".ready0"}, 32'(bus.req0_ready), 32'(v.r0));
    check({v.name, ".ready1"}, 32'(bus.req1_ready), 32'(v.r1));
    check({v.name, ".busy"}, 32'(bus.clr_busy), 32'(v.busy));
    @(posedge clock);
    #1;
    check({v.name, ".we"}, 32'(bus.rf_write_enable), 32'(v.we));
    check({v.name, ".done"}, 32'(bus.clr_done), 32'(v.done));
    if (v.we || v.rst) begin
      check({v.name, ".addr"}, 32'(bus.rf_write_addr), 32'(v.addr));
      check({v.name, ".data"}, 32'(bus.rf_write_data), 32'(v.data));
    end
    @(negedge clock);
  endtask

  function automatic vec_t mk(input string name, input logic rst, input logic clr,
                              input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                              input logic v1, input logic [2:0] a1, input logic [7:0] d1,
                              input logic r0, input logic r1, input logic busy,
                              input logic we, input logic [2:0] addr, input logic [7:0] data,
                              input logic done);
    vec_t v;
    v.name = name; v.rst = rst; v.clr = clr;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.busy = busy;
    v.we = we; v.addr = addr; v.data = data; v.done = done;
    return v;
  endfunction

  initial begin
    //             name     rst clr v0 a0 d0     v1 a1 d1     r0 r1 bsy we addr data   done
    vecs[0]  = mk("rst0",   1, 0,  1, 3, 8'hA5, 1, 2, 8'h22, 0, 0, 0,  0, 0, 8'h00, 0);
    vecs[1]  = mk("lone0",  0, 0,  1, 3, 8'hA5, 0, 0, 8'h00, 1, 0, 0,  1, 3, 8'hA5, 0);
    vecs[2]  = mk("idle0",  0, 0,  0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0,  0, 0, 8'h00, 0);
    vecs[3]  = mk("rst1",   1, 0,  1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 0,  0, 0, 8'h00, 0);
    vecs[4]  = mk("cont0",  0, 0,  1, 1, 8'h11, 1, 2, 8'h22, 1, 0, 0,  1, 1, 8'h11, 0);
    vecs[5]  = mk("cont1",  0, 0,  1, 1, 8'h11, 1, 2, 8'h22, 0, 1, 0,  1, 2, 8'h22, 0);
    vecs[6]  = mk("cont2",  0, 0,  1, 1, 8'h11, 1, 2, 8'h22, 1, 0, 0,  1, 1, 8'h11, 0);
    vecs[7]  = mk("cont3",  0, 0,  1, 1, 8'h11, 1, 2, 8'h22, 0, 1, 0,  1, 2, 8'h22, 0);
    vecs[8]  = mk("lone1",  0, 0,  0, 0, 8'h00, 1, 5, 8'h33, 0, 1, 0,  1, 5, 8'h33, 0);
    vecs[9]  = mk("same0",  0, 0,  1, 4, 8'h44, 0, 0, 8'h00, 1, 0, 0,  1, 4, 8'h44, 0);
    vecs[10] = mk("same1",  0, 0,  1, 4, 8'h55, 0, 0, 8'h00, 1, 0, 0,  1, 4, 8'h55, 0);
    vecs[11] = mk("ptr1",   0, 0,  1, 7, 8'h77, 1, 6, 8'h66, 0, 1, 0,  1, 6, 8'h66, 0);

    reset = 1'b1;
    bus.clr_start = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    @(negedge clock);

    foreach (vecs[i]) run_cycle(vecs[i]);
    run_cycle(mk("idle1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Pointer now names requester 0.

    // Clear start alongside req1: clear wins, no ready.
    run_cycle(mk("clrst", 0, 1, 0, 0, 0, 1, 7, 8'h77, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++) begin
      // Requester inputs wander and clr_start is re-asserted mid-sweep; both ignored.
      run_cycle(mk($sformatf("clr%0d", k), 0, (k == 2), 1'(k % 2), 3'(k), 8'(k + 8'h90),
                   1, 3'(7 - k), 8'(k), 0, 0, 1, 1, 3'(k), 8'h00, (k == 7)));
    end
    // First RUN cycle after the sweep: req1 finally accepted.
    run_cycle(mk("post", 0, 0, 0, 0, 0, 1, 7, 8'h77, 0, 1, 0, 1, 7, 8'h77, 0));
    run_cycle(mk("post1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Move pointer to requester 1, then abandon a clear after three writes.
    run_cycle(mk("ptrset", 0, 0, 1, 2, 8'hC3, 0, 0, 0, 1, 0, 0, 1, 2, 8'hC3, 0));
    run_cycle(mk("clrst2", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      run_cycle(mk($sformatf("clrb%0d", k), 0, 0, 0, 0, 0, 0, 0, 0,
                   0, 0, 1, 1, 3'(k), 8'h00, 0));
    end
    run_cycle(mk("rstmid", 1, 0, 1, 1, 8'h11, 1, 2, 8'h22, 0, 0, 1, 0, 0, 8'h00, 0));
    // Reset restored pointer to requester 0.
    run_cycle(mk("aftrst", 0, 0, 1, 1, 8'h11, 1, 2, 8'h22, 1, 0, 0, 1, 1, 8'h11, 0));
    run_cycle(mk("aftrst1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, write-data width, matching the register-file data width.
REQ-002 Register count is fixed at 8; register address width is fixed at 3.
REQ-003 Port clock  input  1  rising-edge clock for all state.
REQ-004 Port reset  input  1  reset, synchronous, active-high; clock is clock.
REQ-005 Port req0_valid / req1_valid  input  1 each  requester N presents a write.
REQ-006 Port req0_addr / req1_addr  input  3 each  target register.
REQ-007 Port req0_data / req1_data  input  DATA_W each  write value.
REQ-008 Port req0_ready / req1_ready  output  1 each  request accepted this cycle; combinational.
REQ-009 Port clr_start  input  1  request a clear of all 8 registers.
REQ-010 Port clr_busy  output  1  clear sequence in progress.
REQ-011 Port clr_done  output  1  one-cycle pulse when the clear completes.
REQ-012 Ports rf_write_enable (1), rf_write_addr (3), rf_write_data (DATA_W)  output  registered drive to the register-file write port.

Function
REQ-013 FSM states: RUN and CLEAR; reset state RUN.
REQ-014 Transfer on requester N occurs when reqN_valid=1 and reqN_ready=1 in the same cycle; at most one transfer per cycle.
REQ-015 reqN_ready=1 only in RUN, with clr_start=0, and requester N granted; never asserted without reqN_valid.
REQ-016 Grant: a lone valid requester is granted; if both are valid, the requester named by a 1-bit priority pointer is granted.
REQ-017 After every transfer, the priority pointer points to the requester that did not transfer; with no transfer it holds.
REQ-018 Latency: on the edge ending a transfer cycle, rf_write_enable<=1 and addr/data<=transferred values; held for exactly one cycle, then enable returns to 0 unless another transfer occurred.
REQ-019 Requests to the same address on consecutive cycles produce consecutive writes in acceptance order.
REQ-020 clr_start=1 in RUN wins over any valid request in that cycle (no ready); on that edge, state<=CLEAR and the 3-bit counter<=0.
REQ-021 Each edge in CLEAR: rf_write_enable<=1, rf_write_addr<=counter, rf_write_data<=0, counter increments; exactly 8 writes, addresses 0..7 in order.
REQ-022 On the CLEAR edge with counter=7: state<=RUN and clr_done<=1 for one cycle; clr_done is 0 at all other times.
REQ-023 clr_busy=1 exactly while state=CLEAR; all readies are 0 during CLEAR; clr_start during CLEAR is ignored.
REQ-024 In CLEAR, the requester valid/addr/data may change freely; no request is latched or lost beyond the requester's own handshake.

Reset
REQ-025 reset=1 at an edge forces state=RUN, counter=0, priority pointer=0 (requester 0), rf_write_enable=0, rf_write_addr=0, rf_write_data=0, clr_done=0.
REQ-026 Reset mid-CLEAR abandons the sequence with no further writes and no clr_done; readies are 0 while reset=1.

Structure
REQ-027 Shared package rf_ctrl_pkg holds the FSM state encoding, NREG=8, and REG_ADDR_W=3.
REQ-028 The 2-input round-robin grant logic (valids, pointer -> one-hot grant) is sub-module rr_arbiter2; the FSM and output registers live in rf_write_arbiter.

Verification
REQ-029 Lone request: req0 valid, addr=3, data=8'hA5 -> req0_ready same cycle; next cycle, we=1, addr=3, data=A5 for one cycle.
REQ-030 Contention: both valid for 4 cycles after reset (r0 addr1/11, r1 addr2/22) -> grants 0,1,0,1; writes follow one cycle behind.
REQ-031 Clear: clr_start pulse -> clr_busy high for 8 cycles; writes addr 0..7 with data 0 on consecutive cycles; clr_done pulses with the addr-7 write; readies are 0 throughout.
REQ-032 Simultaneous events: clr_start and req1_valid in the same cycle -> req1_ready=0; clear runs; req1 is accepted in the first RUN cycle afterward.
REQ-033 Reset mid-clear after 3 writes -> next cycle: we=0, clr_busy=0, no clr_done; the pointer selects req0 on the next contention.
